field_force_pipe: RTL and testbench

//  Parametrised successor of the single-stage top-nibble forcer on the ALU datapath.

---
 rtl/field_force_pipe.sv | 131 +++++++++++++
 tb/tb_field_force_pipe.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/field_force_pipe.sv
// Field-rewriting stallable pipeline: rewrites A[FIELD_LO +: FIELD_W] per a runtime mode/value.
// Optional feature macro FORCE_COUNT_EN adds a saturating counter of words whose field changed.
module field_force_pipe #(
    parameter int                 WIDTH     = 16,
    parameter int                 FIELD_LO  = 12,
    parameter int                 FIELD_W   = 4,
    parameter int                 DEPTH     = 1,
    parameter logic [FIELD_W-1:0] FORCE_VAL = 4'hF
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   A,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   r,
    input  logic               cfg_we,
    input  logic [1:0]         cfg_mode,
    input  logic [FIELD_W-1:0] cfg_val,
    output logic               busy
`ifdef FORCE_COUNT_EN
    ,
    output logic [15:0]        force_cnt,
    input  logic               force_cnt_clr
`endif
);

    typedef enum logic [1:0] {
        MODE_PASS  = 2'b00,
        MODE_FORCE = 2'b01,
        MODE_OR    = 2'b10,
        MODE_AND   = 2'b11
    } mode_t;

    if (FIELD_LO + FIELD_W > WIDTH) begin : g_bad_field
        $error("field_force_pipe: FIELD_LO+FIELD_W exceeds WIDTH");
    end
    if (DEPTH < 1) begin : g_bad_depth
        $error("field_force_pipe: DEPTH must be at least 1");
    end

    mode_t              mode;
    logic [FIELD_W-1:0] val;

    logic [WIDTH-1:0]   stage_data [DEPTH];
    logic [DEPTH-1:0]   stage_vld;

    logic               adv;
    logic               accept;
    logic [FIELD_W-1:0] f_in;
    logic [FIELD_W-1:0] f_out;
    logic [WIDTH-1:0]   xform;

    assign out_valid = stage_vld[DEPTH-1];
    assign r         = stage_data[DEPTH-1];
    assign adv       = !out_valid || out_ready;
    assign in_ready  = adv;
    assign accept    = in_valid && in_ready;
    assign busy      = |stage_vld;

    always_comb begin
        f_in  = A[FIELD_LO +: FIELD_W];
        f_out = f_in;
        case (mode)
            MODE_PASS:  f_out = f_in;
            MODE_FORCE: f_out = val;
            MODE_OR:    f_out = f_in | val;
            MODE_AND:   f_out = f_in & val;
            default:    f_out = f_in;
        endcase
        xform = A;
        xform[FIELD_LO +: FIELD_W] = f_out;
    end

    // Registered config is what the transform sees, so a same-cycle write only affects later accepts.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            mode <= MODE_FORCE;
            val  <= FORCE_VAL;
        end else if (cfg_we) begin
            mode <= mode_t'(cfg_mode);
            val  <= cfg_val;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            stage_vld <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                stage_data[i] <= '0;
            end
        end else if (adv) begin
            stage_data[0] <= xform;
            stage_vld[0]  <= accept;
            for (int i = 1; i < DEPTH; i++) begin
                stage_data[i] <= stage_data[i-1];
                stage_vld[i]  <= stage_vld[i-1];
            end
        end
    end

`ifdef FORCE_COUNT_EN
    logic [DEPTH-1:0] stage_chg;
    logic             count_evt;

    assign count_evt = out_valid && out_ready && stage_chg[DEPTH-1];

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            stage_chg <= '0;
        end else if (adv) begin
            stage_chg[0] <= (f_out != f_in);
            for (int i = 1; i < DEPTH; i++) begin
                stage_chg[i] <= stage_chg[i-1];
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            force_cnt <= '0;
        end else if (force_cnt_clr) begin
            force_cnt <= '0;
        end else if (count_evt && force_cnt != 16'hFFFF) begin
            force_cnt <= force_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_field_force_pipe.sv
// Directed bench for field_force_pipe: a DEPTH=1 instance for transform/config/counter cases
// and a DEPTH=3 instance for latency, stall and flush cases.
module tb_field_force_pipe;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // DEPTH=1 instance
    logic        rst_1 = 1'b1;
    logic        in_valid_1 = 1'b0, out_ready_1 = 1'b1, cfg_we_1 = 1'b0;
    logic        in_ready_1, out_valid_1, busy_1;
    logic [15:0] a_1 = '0, r_1;
    logic [1:0]  cfg_mode_1 = 2'b01;
    logic [3:0]  cfg_val_1 = 4'hF;
`ifdef FORCE_COUNT_EN
    logic [15:0] force_cnt_1;
    logic        force_cnt_clr_1 = 1'b0;
`endif

    field_force_pipe #(.WIDTH(16), .FIELD_LO(12), .FIELD_W(4), .DEPTH(1), .FORCE_VAL(4'hF)) u_d1 (
        .CLK(CLK), .RST(rst_1),
        .in_valid(in_valid_1), .in_ready(in_ready_1), .A(a_1),
        .out_valid(out_valid_1), .out_ready(out_ready_1), .r(r_1),
        .cfg_we(cfg_we_1), .cfg_mode(cfg_mode_1), .cfg_val(cfg_val_1),
        .busy(busy_1)
`ifdef FORCE_COUNT_EN
        , .force_cnt(force_cnt_1), .force_cnt_clr(force_cnt_clr_1)
`endif
    );

    // DEPTH=3 instance
    logic        rst_3 = 1'b1;
    logic        in_valid_3 = 1'b0, out_ready_3 = 1'b1, cfg_we_3 = 1'b0;
    logic        in_ready_3, out_valid_3, busy_3;
    logic [15:0] a_3 = '0, r_3;
    logic [1:0]  cfg_mode_3 = 2'b01;
    logic [3:0]  cfg_val_3 = 4'hF;
`ifdef FORCE_COUNT_EN
    logic [15:0] force_cnt_3;
    logic        force_cnt_clr_3 = 1'b0;
`endif

    field_force_pipe #(.WIDTH(16), .FIELD_LO(12), .FIELD_W(4), .DEPTH(3), .FORCE_VAL(4'hF)) u_d3 (
        .CLK(CLK), .RST(rst_3),
        .in_valid(in_valid_3), .in_ready(in_ready_3), .A(a_3),
        .out_valid(out_valid_3), .out_ready(out_ready_3), .r(r_3),
        .cfg_we(cfg_we_3), .cfg_mode(cfg_mode_3), .cfg_val(cfg_val_3),
        .busy(busy_3)
`ifdef FORCE_COUNT_EN
        , .force_cnt(force_cnt_3), .force_cnt_clr(force_cnt_clr_3)
`endif
    );

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] got [$];
        logic [15:0] held;
        int          n_acc;
        int          seen;

        // reset state
        step();
        check("rst_r", {16'h0, r_1}, 32'h0);
        check("rst_out_valid", {31'h0, out_valid_1}, 32'h0);
        check("rst_busy", {31'h0, busy_1}, 32'h0);
        rst_1 = 1'b0;
        rst_3 = 1'b0;
        #1;
        check("in_ready_after_rst", {31'h0, in_ready_1}, 32'h1);

        // default FORCE F, one-cycle latency
        in_valid_1 = 1'b1; a_1 = 16'h1234;
        step();
        in_valid_1 = 1'b0;
        check("force_default_r", {16'h0, r_1}, 32'h0000F234);
        check("force_default_valid", {31'h0, out_valid_1}, 32'h1);
        check("busy_with_word", {31'h0, busy_1}, 32'h1);
        step();
        check("drain_valid", {31'h0, out_valid_1}, 32'h0);

        // OR mode
        cfg_we_1 = 1'b1; cfg_mode_1 = 2'b10; cfg_val_1 = 4'h8;
        step();
        cfg_we_1 = 1'b0;
        in_valid_1 = 1'b1; a_1 = 16'h1234;
        step();
        in_valid_1 = 1'b0;
        check("or_mode_r", {16'h0, r_1}, 32'h00009234);

        // AND mode
        cfg_we_1 = 1'b1; cfg_mode_1 = 2'b11; cfg_val_1 = 4'h3;
        step();
        cfg_we_1 = 1'b0;
        in_valid_1 = 1'b1; a_1 = 16'hF0F0;
        step();
        in_valid_1 = 1'b0;
        check("and_mode_r", {16'h0, r_1}, 32'h000030F0);

        // cfg write coincident with accept: old config applies to that word
        cfg_we_1 = 1'b1; cfg_mode_1 = 2'b01; cfg_val_1 = 4'hF;
        step();
        in_valid_1 = 1'b1; a_1 = 16'hAAAA;
        cfg_we_1 = 1'b1; cfg_mode_1 = 2'b00; cfg_val_1 = 4'h0;
        step();
        cfg_we_1 = 1'b0;
        check("cfg_same_cycle_old", {16'h0, r_1}, 32'h0000FAAA);
        step();
        in_valid_1 = 1'b0;
        check("cfg_next_word_new", {16'h0, r_1}, 32'h0000AAAA);
        step();

`ifdef FORCE_COUNT_EN
        cfg_we_1 = 1'b1; cfg_mode_1 = 2'b01; cfg_val_1 = 4'hF;
        force_cnt_clr_1 = 1'b1;
        step();
        cfg_we_1 = 1'b0; force_cnt_clr_1 = 1'b0;
        check("cnt_cleared", {16'h0, force_cnt_1}, 32'h0);
        in_valid_1 = 1'b1; a_1 = 16'h1234;
        step();
        a_1 = 16'hF234;
        step();
        in_valid_1 = 1'b0;
        step();
        check("cnt_one_changed", {16'h0, force_cnt_1}, 32'h1);
        in_valid_1 = 1'b1; a_1 = 16'h1234;
        step();
        in_valid_1 = 1'b0;
        force_cnt_clr_1 = 1'b1;
        step();
        force_cnt_clr_1 = 1'b0;
        check("cnt_clear_wins", {16'h0, force_cnt_1}, 32'h0);
`endif

        // DEPTH=3 stream with a 4-cycle stall
        n_acc = 0;
        held  = '0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            out_ready_3 = !(cyc >= 4 && cyc < 8);
            in_valid_3  = (n_acc < 5);
            a_3         = 16'(n_acc + 1);
            #1;
            if (cyc == 2) check("lat3_not_yet", {31'h0, out_valid_3}, 32'h0);
            if (cyc == 3) begin
                check("lat3_valid", {31'h0, out_valid_3}, 32'h1);
                check("lat3_first_r", {16'h0, r_3}, 32'h0000F001);
            end
            if (cyc == 4) held = r_3;
            if (cyc == 5) check("stall_in_ready", {31'h0, in_ready_3}, 32'h0);
            if (cyc == 7) begin
                check("stall_r_stable", {16'h0, r_3}, {16'h0, held});
                check("stall_out_valid", {31'h0, out_valid_3}, 32'h1);
            end
            if (in_valid_3 && in_ready_3) n_acc++;
            if (out_valid_3 && out_ready_3) got.push_back(r_3);
            step();
        end
        in_valid_3 = 1'b0;
        out_ready_3 = 1'b1;
        check("stream_count", got.size(), 32'd5);
        for (int i = 0; i < 5 && i < got.size(); i++) begin
            check($sformatf("stream_word%0d", i), {16'h0, got[i]}, 32'h0000F001 + i);
        end
        check("stream_idle_busy", {31'h0, busy_3}, 32'h0);

        // flush: two words in flight, async reset mid-cycle
        in_valid_3 = 1'b1; a_3 = 16'h0111;
        step();
        a_3 = 16'h0222;
        step();
        in_valid_3 = 1'b0;
        check("flush_pre_busy", {31'h0, busy_3}, 32'h1);
        #2;
        rst_3 = 1'b1;
        #1;
        check("flush_out_valid", {31'h0, out_valid_3}, 32'h0);
        check("flush_busy", {31'h0, busy_3}, 32'h0);
        step();
        rst_3 = 1'b0;
        seen = 0;
        for (int cyc = 0; cyc < 8; cyc++) begin
            step();
            if (out_valid_3) seen++;
        end
        check("flush_never_output", seen, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
